serial_add_ctrl: RTL

Bit-serial addition controller that time-multiplexes one 1-bit full_adder cell to add two WIDTH-bit operands, LSB first, one bit per clock. It latches the operands on start, steps the full adder WIDTH times while feeding the carry back, then presents the registered result with a one-cycle done pulse. It sits between a requester issuing add jobs and the full-adder datapath, trading latency for area.

---
 rtl/serial_add_ctrl_pkg.sv | 20 ++
 rtl/serial_add_ctrl_if.sv | 31 +++
 rtl/serial_add_ctrl_full_adder.sv | 19 +
 rtl/serial_add_ctrl.sv | 107 ++++++++++
 4 files changed

// File: rtl/serial_add_ctrl_pkg.sv
// ============================================================================
// Module      : serial_add_ctrl_pkg
// Description : Shared state encoding and default width for serial_add_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_add_ctrl_pkg;

    localparam int c_DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/serial_add_ctrl_if.sv
// ============================================================================
// Module      : serial_add_ctrl_if
// Description : Job request / result bundle between requester and adder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface serial_add_ctrl_if #(
    parameter int WIDTH = serial_add_ctrl_pkg::c_DEFAULT_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
    );
endinterface

`default_nettype wire

// File: rtl/serial_add_ctrl_full_adder.sv
// ============================================================================
// Module      : full_adder
// Description : 1-bit full adder cell used as the serial datapath.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module full_adder (
    input  wire logic a,
    input  wire logic b,
    input  wire logic cin,
    output logic      sum,
    output logic      carry
);
    assign sum   = a ^ b ^ cin;
    assign carry = (a & b) | (a & cin) | (b & cin);
endmodule

`default_nettype wire

// File: rtl/serial_add_ctrl.sv
// ============================================================================
// Module      : serial_add_ctrl
// Description : Bit-serial WIDTH-bit adder, LSB first, one bit per clock.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH
) (
    input  wire logic        clk,
    input  wire logic        rst,
    serial_add_ctrl_if.slave bus
);
    localparam int              c_CW   = $clog2(WIDTH + 1);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_r_sh;
    logic [WIDTH-1:0] w_r_next;
    logic [WIDTH-1:0] r_sum;
    logic             r_c;
    logic             r_cout;
    logic [c_CW-1:0]  r_count;
    logic             w_fa_sum;
    logic             w_fa_carry;
    logic             w_load;
    logic             w_last;

    full_adder u_fa (
        .a     (r_a_sh[0]),
        .b     (r_b_sh[0]),
        .cin   (r_c),
        .sum   (w_fa_sum),
        .carry (w_fa_carry)
    );

    // Result register fills from the MSB so the last sum bit lands in place.
    generate
        if (WIDTH == 1) begin : g_single
            assign w_r_next = w_fa_sum;
        end else begin : g_multi
            assign w_r_next = {w_fa_sum, r_r_sh[WIDTH-1:1]};
        end
    endgenerate

    assign w_load = bus.start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_last = (r_state == ST_SHIFT) && (r_count == c_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (bus.start) w_state_next = ST_SHIFT;
            ST_SHIFT: if (r_count == c_LAST) w_state_next = ST_DONE;
            ST_DONE:  w_state_next = bus.start ? ST_SHIFT : ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_r_sh  <= '0;
            r_c     <= 1'b0;
            r_count <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else if (w_load) begin
            r_a_sh  <= bus.a;
            r_b_sh  <= bus.b;
            r_c     <= bus.cin;
            r_count <= '0;
        end else if (r_state == ST_SHIFT) begin
            r_a_sh  <= r_a_sh >> 1;
            r_b_sh  <= r_b_sh >> 1;
            r_r_sh  <= w_r_next;
            r_c     <= w_fa_carry;
            r_count <= r_count + 1'b1;
            if (w_last) begin
                r_sum  <= w_r_next;
                r_cout <= w_fa_carry;
            end
        end
    end

    assign bus.busy = (r_state == ST_SHIFT);
    assign bus.done = (r_state == ST_DONE);
    assign bus.sum  = r_sum;
    assign bus.cout = r_cout;

endmodule

`default_nettype wire
